// File: rtl/idu_decode_stage_if.sv
// IFU -> decode -> EXU handshake bundle; slave is the decode stage, master the surrounding pipe.
interface idu_decode_stage_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic            flush;
   logic [XLEN-1:0] out_pc;
   logic [3:0]      out_alu_sel;
   logic [2:0]      out_imm_type;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic            out_word_op;
   logic            out_illegal;
   logic            out_ebreak;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready, flush,
      output in_ready, out_valid, out_pc, out_alu_sel, out_imm_type, out_imm,
             out_rs1, out_rs2, out_rd, out_word_op, out_illegal, out_ebreak
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_alu_sel, out_imm_type, out_imm,
             out_rs1, out_rs2, out_rd, out_word_op, out_illegal, out_ebreak
   );
endinterface

// File: rtl/idu_decode_stage.sv
// RV32I/RV64I(+M) decode into a one-deep pipeline register, 1-cycle latency.
// Backpressure: holds the bundle while out_ready is low (in_ready low); flush drops held and incoming.
module idu_decode_stage #(
   parameter int XLEN  = 64,
   parameter bit HAS_M = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   idu_decode_stage_if.slave io
);
   localparam bit RV64 = (XLEN == 64);

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SHIFT = 4'd1;
   localparam logic [3:0] ALU_CMP   = 4'd2;
   localparam logic [3:0] ALU_DIV   = 4'd3;
   localparam logic [3:0] ALU_LOGIC = 4'd4;
   localparam logic [3:0] ALU_MUL   = 4'd5;
   localparam logic [3:0] ALU_AUIPC = 4'd6;
   localparam logic [3:0] ALU_LUI   = 4'd7;
   localparam logic [3:0] ALU_NONE  = 4'd15;

   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_U    = 3'd2;
   localparam logic [2:0] IMM_S    = 3'd3;
   localparam logic [2:0] IMM_J    = 3'd4;
   localparam logic [2:0] IMM_B    = 3'd5;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MULD = 7'b0000001;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      alu_sel;
      logic [2:0]      imm_type;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            word_op;
      logic            illegal;
      logic            ebreak;
   } bundle_t;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic signed [31:0] s;
      s = v;
      return XLEN'(s);
   endfunction

   logic [31:0]     instr;
   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [31:0]     imm_i;
   logic [31:0]     imm_s;
   logic [31:0]     imm_b;
   logic [31:0]     imm_u;
   logic [31:0]     imm_j;
   logic [XLEN-1:0] shamt;
   logic [XLEN-1:0] shamt_w;

   assign instr   = io.in_instr;
   assign opc     = instr[6:0];
   assign f3      = instr[14:12];
   assign f7      = instr[31:25];
   assign imm_i   = {{20{instr[31]}}, instr[31:20]};
   assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u   = {instr[31:12], 12'b0};
   assign imm_j   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign shamt   = RV64 ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
   assign shamt_w = XLEN'(instr[24:20]);

   logic [3:0] alu;
   logic [2:0] itype;
   logic       legal;
   logic       wop;
   logic       sh_imm;
   logic       sh_imm_w;

   always_comb begin
      alu      = ALU_NONE;
      itype    = IMM_NONE;
      legal    = 1'b0;
      wop      = 1'b0;
      sh_imm   = 1'b0;
      sh_imm_w = 1'b0;
      case (opc)
         OPC_LOAD: begin
            alu   = ALU_ADD;
            itype = IMM_I;
            legal = (f3 != 3'd7) && (RV64 || (f3 != 3'd3 && f3 != 3'd6));
         end
         OPC_MISC_MEM: legal = (f3 == 3'd0);
         OPC_OP_IMM: begin
            itype = IMM_I;
            legal = 1'b1;
            case (f3)
               3'd0:               alu = ALU_ADD;
               3'd2, 3'd3:         alu = ALU_CMP;
               3'd4, 3'd6, 3'd7:   alu = ALU_LOGIC;
               3'd1: begin
                  alu    = ALU_SHIFT;
                  sh_imm = 1'b1;
                  legal  = (instr[31:26] == 6'b000000) && (RV64 || !instr[25]);
               end
               default: begin
                  alu    = ALU_SHIFT;
                  sh_imm = 1'b1;
                  legal  = (instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000)
                           && (RV64 || !instr[25]);
               end
            endcase
         end
         OPC_AUIPC: begin
            alu   = ALU_AUIPC;
            itype = IMM_U;
            legal = 1'b1;
         end
         OPC_OP_IMM32: begin
            itype = IMM_I;
            wop   = 1'b1;
            case (f3)
               3'd0: begin
                  alu   = ALU_ADD;
                  legal = RV64;
               end
               3'd1: begin
                  alu      = ALU_SHIFT;
                  sh_imm_w = 1'b1;
                  legal    = RV64 && (f7 == F7_BASE);
               end
               3'd5: begin
                  alu      = ALU_SHIFT;
                  sh_imm_w = 1'b1;
                  legal    = RV64 && (f7 == F7_BASE || f7 == F7_ALT);
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            alu   = ALU_ADD;
            itype = IMM_S;
            legal = (f3 < 3'd3) || (RV64 && f3 == 3'd3);
         end
         OPC_OP: begin
            case (f7)
               F7_BASE: begin
                  legal = 1'b1;
                  case (f3)
                     3'd0:             alu = ALU_ADD;
                     3'd1, 3'd5:       alu = ALU_SHIFT;
                     3'd2, 3'd3:       alu = ALU_CMP;
                     default:          alu = ALU_LOGIC;
                  endcase
               end
               F7_ALT: begin
                  legal = (f3 == 3'd0) || (f3 == 3'd5);
                  alu   = (f3 == 3'd0) ? ALU_ADD : ALU_SHIFT;
               end
               F7_MULD: begin
                  legal = HAS_M;
                  alu   = f3[2] ? ALU_DIV : ALU_MUL;
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            alu   = ALU_LUI;
            itype = IMM_U;
            legal = 1'b1;
         end
         OPC_OP32: begin
            wop = 1'b1;
            case (f7)
               F7_BASE: begin
                  legal = RV64 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
                  alu   = (f3 == 3'd0) ? ALU_ADD : ALU_SHIFT;
               end
               F7_ALT: begin
                  legal = RV64 && (f3 == 3'd0 || f3 == 3'd5);
                  alu   = (f3 == 3'd0) ? ALU_ADD : ALU_SHIFT;
               end
               F7_MULD: begin
                  // Only mulw exists among the word multiplies; mulhw etc. are not defined.
                  legal = RV64 && HAS_M && (f3 == 3'd0 || f3[2]);
                  alu   = f3[2] ? ALU_DIV : ALU_MUL;
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_BRANCH: begin
            alu   = ALU_CMP;
            itype = IMM_B;
            legal = (f3 != 3'd2) && (f3 != 3'd3);
         end
         OPC_JALR: begin
            alu   = ALU_ADD;
            itype = IMM_I;
            legal = (f3 == 3'd0);
         end
         OPC_JAL: begin
            alu   = ALU_ADD;
            itype = IMM_J;
            legal = 1'b1;
         end
         OPC_SYSTEM: legal = (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
         default:    legal = 1'b0;
      endcase
      if (instr[1:0] != 2'b11) begin
         legal = 1'b0;
      end
   end

   bundle_t dec;

   always_comb begin
      dec          = '0;
      dec.pc       = io.in_pc;
      dec.alu_sel  = legal ? alu : ALU_NONE;
      dec.imm_type = legal ? itype : IMM_NONE;
      dec.rs1      = instr[19:15];
      dec.rs2      = instr[24:20];
      dec.rd       = instr[11:7];
      dec.word_op  = legal && wop;
      dec.illegal  = !legal;
      dec.ebreak   = (instr == INSTR_EBREAK);
      case (dec.imm_type)
         IMM_I: begin
            if (sh_imm)
               dec.imm = shamt;
            else if (sh_imm_w)
               dec.imm = shamt_w;
            else
               dec.imm = sext32(imm_i);
         end
         IMM_U:   dec.imm = sext32(imm_u);
         IMM_S:   dec.imm = sext32(imm_s);
         IMM_J:   dec.imm = sext32(imm_j);
         IMM_B:   dec.imm = sext32(imm_b);
         default: dec.imm = '0;
      endcase
   end

   bundle_t bundle_q;
   logic    bundle_vld;
   logic    capture;

   assign io.in_ready = !bundle_vld || io.out_ready;
   assign capture     = io.in_valid && io.in_ready && !io.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bundle_vld <= 1'b0;
         bundle_q   <= '0;
      end else begin
         if (io.flush)
            bundle_vld <= 1'b0;
         else if (capture)
            bundle_vld <= 1'b1;
         else if (io.out_ready)
            bundle_vld <= 1'b0;
         if (capture)
            bundle_q <= dec;
      end
   end

   assign io.out_valid    = bundle_vld;
   assign io.out_pc       = bundle_q.pc;
   assign io.out_alu_sel  = bundle_q.alu_sel;
   assign io.out_imm_type = bundle_q.imm_type;
   assign io.out_imm      = bundle_q.imm;
   assign io.out_rs1      = bundle_q.rs1;
   assign io.out_rs2      = bundle_q.rs2;
   assign io.out_rd       = bundle_q.rd;
   assign io.out_word_op  = bundle_q.word_op;
   assign io.out_illegal  = bundle_q.illegal;
   assign io.out_ebreak   = bundle_q.ebreak;
endmodule
